// File: rtl/sprite_layer_scaled_if.sv
// ROM and palette bus between the sprite layer (master) and its external
// sprite ROM / palette instances (slave).
interface sprite_layer_scaled_if #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_address,
        output pal_index,
        input  rom_q,
        input  pal_red,
        input  pal_green,
        input  pal_blue
    );

    modport slave (
        input  rom_address,
        input  pal_index,
        output rom_q,
        output pal_red,
        output pal_green,
        output pal_blue
    );
endinterface

// File: rtl/sprite_layer_scaled.sv
// Pipelined, power-of-two scaled, colour-keyed ROM sprite layer for a 640x480 raster.
// Optional horizontal mirroring is compiled in when SPRITE_FLIP_EN is defined.
module sprite_layer_scaled #(
    parameter int SPR_W       = 320,
    parameter int SPR_H       = 240,
    parameter int ADDR_W      = 17,
    parameter int IDX_W       = 4,
    parameter int ROM_LATENCY = 1,
    parameter int KEY_INDEX   = 0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       frame_start,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [1:0] scale_log2,
    input  logic       enable,
    input  logic       key_en,
    input  logic       flip_x,
    sprite_layer_scaled_if.master bus,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       opaque
);

    logic [9:0] act_x;
    logic [9:0] act_y;
    logic [1:0] act_scale;
    logic       act_enable;
    logic       act_key_en;
`ifdef SPRITE_FLIP_EN
    logic       act_flip;
`else
    logic       flip_x_unused;
    assign flip_x_unused = flip_x;
`endif

    // Parameters only change at a frame boundary; reset takes priority.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            act_x      <= '0;
            act_y      <= '0;
            act_scale  <= '0;
            act_enable <= 1'b0;
            act_key_en <= 1'b0;
`ifdef SPRITE_FLIP_EN
            act_flip   <= 1'b0;
`endif
        end else if (frame_start) begin
            act_x      <= pos_x;
            act_y      <= pos_y;
            act_scale  <= scale_log2;
            act_enable <= enable;
            act_key_en <= key_en;
`ifdef SPRITE_FLIP_EN
            act_flip   <= flip_x;
`endif
        end
    end

    // Stage 0: raster-relative offset, bounds test, source texel coordinates
    logic signed [12:0] dx_p0;
    logic signed [12:0] dy_p0;
    logic        [12:0] ext_w_p0;
    logic        [12:0] ext_h_p0;
    logic        [12:0] sx_p0;
    logic        [12:0] sy_p0;
    logic               hit_p0;
    logic               vld_p0;
    logic [ADDR_W-1:0]  addr_p0;

    always_comb begin
        dx_p0    = $signed({3'b000, DrawX}) - $signed({3'b000, act_x});
        dy_p0    = $signed({3'b000, DrawY}) - $signed({3'b000, act_y});
        ext_w_p0 = 13'(SPR_W) << act_scale;
        ext_h_p0 = 13'(SPR_H) << act_scale;
        hit_p0   = !dx_p0[12] && !dy_p0[12] &&
                   (13'(dx_p0) < ext_w_p0) && (13'(dy_p0) < ext_h_p0);
        sx_p0    = 13'(dx_p0) >> act_scale;
        sy_p0    = 13'(dy_p0) >> act_scale;
`ifdef SPRITE_FLIP_EN
        if (act_flip) begin
            sx_p0 = 13'(SPR_W - 1) - sx_p0;
        end
`endif
        addr_p0  = ADDR_W'(sy_p0) * ADDR_W'(SPR_W) + ADDR_W'(sx_p0);
        vld_p0   = hit_p0 && blank && act_enable;
    end

    // Stage 1: registered ROM address; ownership and key mode ride alongside
    // so a mid-pipeline frame_start cannot alter pixels already in flight.
    logic [ROM_LATENCY:0] vld_p1;
    logic [ROM_LATENCY:0] key_p1;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            bus.rom_address <= '0;
            vld_p1          <= '0;
            key_p1          <= '0;
        end else begin
            bus.rom_address <= hit_p0 ? addr_p0 : '0;
            vld_p1          <= {vld_p1[ROM_LATENCY-1:0], vld_p0};
            key_p1          <= {key_p1[ROM_LATENCY-1:0], act_key_en};
        end
    end

    assign bus.pal_index = bus.rom_q;

    // Stage 2: rom_q is valid here; resolve transparency and register colour
    logic own_p2;

    always_comb begin
        own_p2 = vld_p1[ROM_LATENCY] &&
                 !(key_p1[ROM_LATENCY] && (bus.rom_q == IDX_W'(KEY_INDEX)));
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            opaque <= 1'b0;
        end else if (own_p2) begin
            red    <= bus.pal_red;
            green  <= bus.pal_green;
            blue   <= bus.pal_blue;
            opaque <= 1'b1;
        end else begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            opaque <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_layer_scaled.sv
// Directed bench for sprite_layer_scaled: 16x8 sprite, ROM word[a]=a[3:0], palette rgb=index.
module tb_sprite_layer_scaled;

    localparam int SPR_W  = 16;
    localparam int SPR_H  = 8;
    localparam int ADDR_W = 7;
    localparam int IDX_W  = 4;

    logic       vga_clk;
    logic       reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       frame_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] scale_log2;
    logic       enable;
    logic       key_en;
    logic       flip_x;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       opaque;

    int checks;
    int failures;

    sprite_layer_scaled_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    sprite_layer_scaled #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .ROM_LATENCY(1), .KEY_INDEX(0)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .scale_log2(scale_log2), .enable(enable), .key_en(key_en), .flip_x(flip_x),
        .bus(bus.master), .red(red), .green(green), .blue(blue), .opaque(opaque)
    );

    // One-cycle ROM holding its own low address bits; palette maps index to grey.
    always_ff @(posedge vga_clk) bus.rom_q <= bus.rom_address[3:0];
    assign bus.pal_red   = bus.pal_index;
    assign bus.pal_green = bus.pal_index;
    assign bus.pal_blue  = bus.pal_index;

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [1:0] sc;
        logic       en;
        logic       ke;
        logic       fl;
        logic [9:0] dx;
        logic [9:0] dy;
        logic       bl;
        logic [6:0] e_addr;
        logic       e_op;
        logic [3:0] e_rgb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        pos_x = v.px; pos_y = v.py; scale_log2 = v.sc;
        enable = v.en; key_en = v.ke; flip_x = v.fl;
        frame_start = 1'b1; blank = 1'b0; DrawX = '0; DrawY = '0;
        tick();
        frame_start = 1'b0;
        DrawX = v.dx; DrawY = v.dy; blank = v.bl;
        tick();
        check({tag, "_addr"}, 32'(bus.rom_address), 32'(v.e_addr));
        blank = 1'b0; DrawX = '0; DrawY = '0;
        tick();
        tick();
        check({tag, "_opaque"}, 32'(opaque), 32'(v.e_op));
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'({v.e_rgb, v.e_rgb, v.e_rgb}));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs[0]  = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b0, 10'd103, 10'd52, 1'b1, 7'd35, 1'b1, 4'd3};
        vecs[1]  = '{10'd100, 10'd50, 2'd2, 1'b1, 1'b0, 1'b0, 10'd163, 10'd50, 1'b1, 7'd15, 1'b1, 4'd15};
        vecs[2]  = '{10'd100, 10'd50, 2'd2, 1'b1, 1'b0, 1'b0, 10'd164, 10'd50, 1'b1, 7'd0, 1'b0, 4'd0};
        vecs[3]  = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b1, 1'b0, 10'd100, 10'd50, 1'b1, 7'd0, 1'b0, 4'd0};
        vecs[4]  = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b0, 10'd100, 10'd50, 1'b1, 7'd0, 1'b1, 4'd0};
        vecs[5]  = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b0, 10'd103, 10'd52, 1'b0, 7'd35, 1'b0, 4'd0};
        vecs[6]  = '{10'd100, 10'd50, 2'd0, 1'b0, 1'b0, 1'b0, 10'd103, 10'd52, 1'b1, 7'd35, 1'b0, 4'd0};
        vecs[7]  = '{10'd630, 10'd470, 2'd0, 1'b1, 1'b0, 1'b0, 10'd639, 10'd477, 1'b1, 7'd121, 1'b1, 4'd9};
        vecs[8]  = '{10'd630, 10'd470, 2'd0, 1'b1, 1'b0, 1'b0, 10'd639, 10'd479, 1'b1, 7'd0, 1'b0, 4'd0};
        vecs[9]  = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b0, 10'd99, 10'd50, 1'b1, 7'd0, 1'b0, 4'd0};
        vecs[10] = '{10'd0, 10'd0, 2'd3, 1'b1, 1'b0, 1'b0, 10'd127, 10'd63, 1'b1, 7'd127, 1'b1, 4'd15};
        vecs[11] = '{10'd0, 10'd0, 2'd3, 1'b1, 1'b0, 1'b0, 10'd128, 10'd63, 1'b1, 7'd0, 1'b0, 4'd0};
        vecs[12] = '{10'd1023, 10'd1023, 2'd0, 1'b1, 1'b0, 1'b0, 10'd639, 10'd479, 1'b1, 7'd0, 1'b0, 4'd0};
`ifdef SPRITE_FLIP_EN
        vecs[13] = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b1, 10'd100, 10'd50, 1'b1, 7'd15, 1'b1, 4'd15};
`else
        vecs[13] = '{10'd100, 10'd50, 2'd0, 1'b1, 1'b0, 1'b1, 10'd100, 10'd50, 1'b1, 7'd0, 1'b1, 4'd0};
`endif

        reset = 1'b1; frame_start = 1'b1;
        DrawX = 10'd103; DrawY = 10'd52; blank = 1'b1;
        pos_x = 10'd100; pos_y = 10'd50; scale_log2 = 2'd0;
        enable = 1'b1; key_en = 1'b0; flip_x = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst%0d_addr", i), 32'(bus.rom_address), 32'd0);
            check($sformatf("rst%0d_opaque", i), 32'(opaque), 32'd0);
        end
        reset = 1'b0; frame_start = 1'b0; blank = 1'b0;
        tick();
        check("rst_rel_addr", 32'(bus.rom_address), 32'd0);
        check("rst_rel_rgb_op", 32'({red, green, blue, opaque}), 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Latch a plain sprite at (100,50), then move the shadow without a frame_start.
        pos_x = 10'd100; pos_y = 10'd50; scale_log2 = 2'd0;
        enable = 1'b1; key_en = 1'b0; flip_x = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; pos_x = 10'd200;
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
        tick();
        DrawX = 10'd200;
        tick();
        blank = 1'b0;
        tick();
        check("shadow_old_pos_hit", 32'(opaque), 32'd1);
        tick();
        check("shadow_new_pos_ignored", 32'(opaque), 32'd0);

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        DrawX = 10'd200; blank = 1'b1;
        tick();
        DrawX = 10'd100;
        tick();
        blank = 1'b0;
        tick();
        check("latched_new_pos_hit", 32'(opaque), 32'd1);
        tick();
        check("latched_old_pos_miss", 32'(opaque), 32'd0);

        // frame_start in the same cycle as a hit pixel: that pixel keeps the old parameters.
        DrawX = 10'd200; blank = 1'b1;
        pos_x = 10'd100; enable = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        blank = 1'b0;
        tick();
        check("midpipe_inflight_hit", 32'(opaque), 32'd1);
        tick();
        check("midpipe_new_params", 32'(opaque), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
